operand_streamer: RTL and testbench
===================================

OPERAND_STREAMER -- requirements
Module: operand_streamer

Interface
REQ-001 Parameter ADDR_W, default 8: memory word-address width.
REQ-002 Parameter DATA_W, default 32: memory and stream word width.
REQ-003 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to stream an operand; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first word address of the operand, captured on accepted start.
REQ-007 length  input  ADDR_W  word count, captured on accepted start; 0 means empty operand.
REQ-008 mem_rd  output  1  read strobe to the block memory.
REQ-009 mem_addr  output  ADDR_W  read address, valid while mem_rd=1.
REQ-010 mem_data  input  DATA_W  memory read data, valid exactly one cycle after the mem_rd cycle.
REQ-011 out_valid  output  1  stream word available.
REQ-012 out_ready  input  1  downstream accepts the word when out_valid=1 and out_ready=1.
REQ-013 out_data  output  DATA_W  stream word.
REQ-014 out_last  output  1  marks the final word of the operand, qualified by out_valid.
REQ-015 busy  output  1  high from accepted start until the done cycle, inclusive.
REQ-016 done  output  1  one-cycle pulse after the last word transfers, or after an empty operand.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, STREAM, DRAIN and DONE.
REQ-018 In IDLE, start=1 with length>0 SHALL capture base_addr and length and enter STREAM; with length=0 it SHALL enter DONE without any mem_rd.
REQ-019 In STREAM, mem_rd SHALL be asserted only when the output buffer has at least one free entry, counting the read already in flight.
REQ-020 Read addresses SHALL step by one per issued read and wrap modulo 2^ADDR_W (base 0xFE, length 3 -> 0xFE, 0xFF, 0x00).
REQ-021 After the length-th read issues, the FSM SHALL enter DRAIN; DRAIN SHALL go to DONE in the cycle the out_last word transfers.
REQ-022 DONE SHALL assert done for one cycle and return to IDLE.
REQ-023 The output buffer SHALL hold two words, SHALL preserve word order and SHALL neither drop nor duplicate a word under any out_ready pattern.
REQ-024 out_data and out_valid SHALL come from registers; minimum latency from start to first out_valid is 2 cycles.
REQ-025 With out_ready held high, the block SHALL sustain one word per cycle; operand of N words completes (done) at cycle N+2 after start.
REQ-026 out_valid, out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 The block SHALL never issue more than length reads per operand.

Reset
REQ-029 reset=1 SHALL force IDLE, empty the buffer and drive mem_rd=0, out_valid=0, out_last=0, busy=0 and done=0 in the next cycle, including mid-operation.
REQ-030 mem_addr and out_data SHALL reset to 0.
REQ-031 A read in flight at reset SHALL be discarded.

Configuration
REQ-032 Macro OPERAND_STREAMER_REVERSE_EN: when defined, reads SHALL start at base_addr+length-1 and decrement with wrap, so the most significant word is streamed first; when undefined, reads increment from base_addr per REQ-020.
REQ-033 Handshake, latency and out_last behaviour SHALL be identical in both builds.

Structure
REQ-034 A shared package operand_streamer_pkg SHALL hold the FSM state enum and the default ADDR_W/DATA_W constants.
REQ-035 The two-entry buffer SHALL be a sub-module named stream_fifo2 with valid/ready on both sides.

Verification
REQ-036 base 0x10, length 4, memory[i]=i, out_ready=1 -> out_data 0x10..0x13 on consecutive cycles, out_last with 0x13, done 6 cycles after start.
REQ-037 length 0 -> no mem_rd, no out_valid, done one cycle after start; busy high for exactly that cycle span.
REQ-038 base 0xFE, length 3 -> mem_addr 0xFE, 0xFF, 0x00; with REVERSE_EN defined -> 0x00, 0xFF, 0xFE.
REQ-039 length 8, out_ready toggled pseudo-randomly -> all 8 words exactly once, in order, outputs stable while stalled, at most 2 words buffered.
REQ-040 reset asserted on the 3rd word of a length-8 operand -> next cycle all outputs at reset values; new start streams correctly from scratch.
REQ-041 start pulsed again mid-stream -> ignored; captured base/length unchanged; single done.

Source files
------------

// File: rtl/operand_streamer_pkg.sv
// Shared types and default widths for the operand streamer.
package operand_streamer_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/operand_streamer_if.sv
// Start/memory/stream signal bundle of the operand streamer.
interface operand_streamer_if import operand_streamer_pkg::*; #(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, length, mem_data, out_ready,
        input  mem_rd, mem_addr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  start, base_addr, length, mem_data, out_ready,
        output mem_rd, mem_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready buffer; the head entry is the registered output.
module stream_fifo2 import operand_streamer_pkg::*; #(
    parameter int W = DEFAULT_DATA_W + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic         head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic         push, pop;

    assign in_ready_o  = !tail_vld_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = head_vld_q && out_ready_i;
    assign out_valid_o = head_vld_q;
    assign out_data_o  = head_q;
    assign count_o     = 2'(head_vld_q) + 2'(tail_vld_q);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        if (pop) begin
            if (tail_vld_q) begin
                head_d     = tail_q;
                tail_vld_d = push;
                if (push) tail_d = in_data_i;
            end else begin
                head_vld_d = push;
                if (push) head_d = in_data_i;
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_vld_d = 1'b1;
                head_d     = in_data_i;
            end else begin
                tail_vld_d = 1'b1;
                tail_d     = in_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
        end
    end
endmodule

// File: rtl/operand_streamer.sv
// Streams an operand from block memory into a valid/ready word stream.
// Define OPERAND_STREAMER_REVERSE_EN to read from the top word downwards.
module operand_streamer import operand_streamer_pkg::*; #(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input logic                clk,
    input logic                reset,
    operand_streamer_if.slave  bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rem_q, rem_d, first_addr, rd_addr;
    logic              rd_en, rd_last, inflight_q, inflight_last_q, pop;
    logic [2:0]        occ;
    logic              fifo_in_ready, fifo_out_valid;
    logic [DATA_W:0]   fifo_out_word;
    logic [1:0]        fifo_count;

    function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a);
`ifdef OPERAND_STREAMER_REVERSE_EN
        return a - ADDR_W'(1);
`else
        return a + ADDR_W'(1);
`endif
    endfunction

`ifdef OPERAND_STREAMER_REVERSE_EN
    assign first_addr = bus.base_addr + bus.length - ADDR_W'(1);
`else
    assign first_addr = bus.base_addr;
`endif

    // Buffer slots claimed by held words plus the read in flight, less the word leaving now.
    assign pop = fifo_out_valid && bus.out_ready;
    assign occ = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        rd_en   = 1'b0;
        rd_addr = addr_q;
        unique case (state_q)
            IDLE: begin
                // First read issues in the accepting cycle; the buffer is empty here.
                if (bus.start) begin
                    if (bus.length == '0) begin
                        state_d = DONE;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = first_addr;
                        addr_d  = step(first_addr);
                        rem_d   = bus.length - ADDR_W'(1);
                        state_d = (bus.length == ADDR_W'(1)) ? DRAIN : STREAM;
                    end
                end
            end
            STREAM: begin
                if (occ <= 3'd1) begin
                    rd_en  = 1'b1;
                    addr_d = step(addr_q);
                    rem_d  = rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN:   if (pop && fifo_out_word[0]) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_last = rd_en && (rem_d == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_last;
        end
    end

    stream_fifo2 #(.W(DATA_W + 1)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (inflight_q),
        .in_ready_o  (fifo_in_ready),
        .in_data_i   ({bus.mem_data, inflight_last_q}),
        .out_valid_o (fifo_out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (fifo_out_word),
        .count_o     (fifo_count)
    );

    assert property (@(posedge clk) disable iff (reset) inflight_q |-> fifo_in_ready);

    assign bus.mem_rd    = rd_en;
    assign bus.mem_addr  = rd_addr;
    assign bus.out_valid = fifo_out_valid;
    assign bus.out_data  = fifo_out_word[DATA_W:1];
    assign bus.out_last  = fifo_out_word[0] && fifo_out_valid;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_operand_streamer.sv
// Scoreboard bench for operand_streamer: queue model of addresses/words, negedge monitor.
module tb_operand_streamer;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;

    operand_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    operand_streamer #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed { logic [DW-1:0] data; logic last; } word_t;

    word_t          exp_q[$];
    logic [AW-1:0]  exp_addr_q[$];
    logic [DW-1:0]  memarr [256];
    int             errors = 0;
    int             checks = 0;
    int             pending_done = 0;
    int             outstanding = 0;
    int             max_outstanding = 0;
    int             xfer_cnt = 0;
    int             exp_lat = 0;
    time            t_start = 0;
    bit             chk_lat = 1'b0, first_seen = 1'b0, rand_ready = 1'b0, stalled_prev = 1'b0;
    logic [DW:0]    prev_word;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic void flag(string name, string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // Memory answers exactly one cycle after the read strobe, garbage otherwise.
    always @(posedge clk) bus.mem_data <= bus.mem_rd ? memarr[bus.mem_addr] : DW'($urandom);

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (bus.mem_rd) begin
                outstanding++;
                if (exp_addr_q.size() == 0)
                    flag("mem_rd", $sformatf("got read at %0h, expected no read", bus.mem_addr));
                else
                    check("mem_addr", 64'(bus.mem_addr), 64'(exp_addr_q.pop_front()));
            end
            if (stalled_prev) begin
                check("stall_valid", 64'(bus.out_valid), 64'(1));
                check("stall_word", 64'({bus.out_data, bus.out_last}), 64'(prev_word));
            end
            if (bus.out_valid && chk_lat && !first_seen) begin
                first_seen = 1'b1;
                check("first_valid_latency", 64'(($time - t_start + 5) / 10), 64'(2));
            end
            if (bus.out_valid && bus.out_ready) begin
                word_t w;
                outstanding--;
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    flag("out_word", $sformatf("got %0h, expected no word", bus.out_data));
                end else begin
                    w = exp_q.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(w.data));
                    check("out_last", 64'(bus.out_last), 64'(w.last));
                end
            end
            if (outstanding > max_outstanding) max_outstanding = outstanding;
            if (bus.done) begin
                if (pending_done == 0) begin
                    flag("done", "got done pulse, expected none");
                end else begin
                    pending_done--;
                    check("words_left_at_done", 64'(exp_q.size()), 64'(0));
                    check("reads_left_at_done", 64'(exp_addr_q.size()), 64'(0));
                    check("busy_at_done", 64'(bus.busy), 64'(1));
                    check("buffered_le_2", 64'(max_outstanding <= 2), 64'(1));
                    if (chk_lat)
                        check("done_latency", 64'(($time - t_start + 5) / 10), 64'(exp_lat));
                end
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            prev_word    = {bus.out_data, bus.out_last};
        end
    end

    task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] len, input bit lat);
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.base_addr   = base;
        bus.length      = len;
        max_outstanding = 0;
        chk_lat         = lat;
        first_seen      = 1'b0;
        exp_lat         = (len == 0) ? 1 : int'(len) + 2;
        for (int k = 0; k < int'(len); k++) begin
            logic [AW-1:0] a;
`ifdef OPERAND_STREAMER_REVERSE_EN
            a = AW'(int'(base) + int'(len) - 1 - k);
`else
            a = AW'(int'(base) + k);
`endif
            exp_addr_q.push_back(a);
            exp_q.push_back('{data: memarr[a], last: (k == int'(len) - 1)});
        end
        pending_done++;
        @(posedge clk);
        t_start = $time;
        #1;
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.length    = AW'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pending_done > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (pending_done > 0) begin
            flag("timeout", $sformatf("got no done after %0d cycles, expected done", n));
            pending_done = 0;
            exp_q.delete();
            exp_addr_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_rd"},    64'(bus.mem_rd),    64'(0));
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_out_last"},  64'(bus.out_last),  64'(0));
        check({tag, "_busy"},      64'(bus.busy),      64'(0));
        check({tag, "_done"},      64'(bus.done),      64'(0));
        check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'(0));
        check({tag, "_out_data"},  64'(bus.out_data),  64'(0));
    endtask

    initial begin
        int base_x;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        for (int i = 0; i < 256; i++) memarr[i] = DW'(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        do_start(8'h10, 8'd4, 1'b1);
        wait_idle();

        do_start(8'h55, 8'd0, 1'b1);
        @(negedge clk);
        check("len0_busy_c1", 64'(bus.busy), 64'(1));
        check("len0_done_c1", 64'(bus.done), 64'(1));
        @(negedge clk);
        check("len0_busy_c2", 64'(bus.busy), 64'(0));
        check("len0_done_c2", 64'(bus.done), 64'(0));
        wait_idle();

        do_start(8'hFE, 8'd3, 1'b1);
        wait_idle();

        for (int i = 0; i < 256; i++) memarr[i] = $urandom;
        rand_ready = 1'b1;
        do_start(8'h80, 8'd8, 1'b0);
        wait_idle();

        do_start(8'h40, 8'd6, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.base_addr = 8'h90; bus.length = 8'd2;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_idle();
        repeat (10) @(posedge clk);
        rand_ready = 1'b0;

        base_x = xfer_cnt;
        do_start(8'h20, 8'd8, 1'b0);
        for (int n = 0; n < 50 && xfer_cnt < base_x + 2; n++) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        pending_done = 0;
        outstanding  = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        do_start(8'h30, 8'd5, 1'b1);
        wait_idle();

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 256; i++) memarr[i] = $urandom;
            rand_ready = (t % 2) == 1;
            do_start(AW'($urandom), AW'($urandom_range(0, 10)), !rand_ready);
            wait_idle();
        end
        rand_ready = 1'b0;
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
